// File: rtl/match_scoreboard.sv
// rtl/match_scoreboard.sv - match controller: round count, saturating per-player scores, champion resolve
module match_scoreboard #(
    parameter int NUM_PLAYERS = 2,
    parameter int MAX_ROUNDS  = 3,
    parameter int WIN_SCORE   = 2,
    parameter int SCORE_W     = 2,
    parameter int RND_W       = $clog2(MAX_ROUNDS + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           ack,
    input  logic                           round_done,
    input  logic [NUM_PLAYERS-1:0]         round_winner,
    output logic [RND_W-1:0]               round,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic                           playing,
    output logic                           match_over,
    output logic [NUM_PLAYERS-1:0]         champion,
    output logic                           illegal_winner,
    output logic                           restartgame
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [SCORE_W-1:0] SC_MAX  = '1;
    localparam logic [SCORE_W-1:0] WIN_SC  = SCORE_W'(WIN_SCORE);
    localparam logic [RND_W-1:0]   MAX_RND = RND_W'(MAX_ROUNDS);

    state_t                           state_q, state_d;
    logic [RND_W-1:0]                 round_q, round_d;
    logic [NUM_PLAYERS*SCORE_W-1:0]   scores_q, scores_d;
    logic [NUM_PLAYERS-1:0]           champion_q, champion_d;
    logic                             illegal_q, illegal_d;
    logic                             restart_q, restart_d;

    logic                             multi_hot;
    logic [SCORE_W-1:0]               sc_upd [NUM_PLAYERS];
    logic [NUM_PLAYERS*SCORE_W-1:0]   scores_upd;
    logic [SCORE_W-1:0]               max_sc;
    logic [NUM_PLAYERS-1:0]           top_mask;
    logic [NUM_PLAYERS-1:0]           win_hit;
    logic [RND_W-1:0]                 round_inc;

    // Candidate scores if the current round_done were accepted; a multi-hot winner scores nobody.
    always_comb begin
        multi_hot  = !$onehot0(round_winner);
        scores_upd = scores_q;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            sc_upd[p] = scores_q[p*SCORE_W +: SCORE_W];
            if (round_winner[p] && !multi_hot && (sc_upd[p] != SC_MAX)) begin
                sc_upd[p] = sc_upd[p] + 1'b1;
            end
            scores_upd[p*SCORE_W +: SCORE_W] = sc_upd[p];
        end
    end

    // Post-update leader mask and win-threshold hits used by the end-of-match check.
    always_comb begin
        max_sc = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (sc_upd[p] > max_sc) begin
                max_sc = sc_upd[p];
            end
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            top_mask[p] = (sc_upd[p] == max_sc);
            win_hit[p]  = (sc_upd[p] == WIN_SC);
        end
    end

    // Round counter pins at MAX_ROUNDS so it can never wrap.
    assign round_inc = (round_q == MAX_RND) ? round_q : round_q + 1'b1;

    // Next-state and datapath updates; start always wins over ack and round_done.
    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        scores_d   = scores_q;
        champion_d = champion_q;
        illegal_d  = illegal_q;
        restart_d  = 1'b0;
        if (start) begin
            state_d    = PLAY;
            round_d    = '0;
            scores_d   = '0;
            champion_d = '0;
            illegal_d  = 1'b0;
            restart_d  = 1'b1;
        end else begin
            case (state_q)
                PLAY: begin
                    if (round_done) begin
                        round_d  = round_inc;
                        scores_d = scores_upd;
                        if (multi_hot) begin
                            illegal_d = 1'b1;
                        end
                        if (|win_hit) begin
                            state_d    = OVER;
                            champion_d = win_hit;
                        end else if (round_inc == MAX_RND) begin
                            state_d    = OVER;
                            champion_d = $onehot(top_mask) ? top_mask : '0;
                        end
                    end
                end
                OVER: begin
                    if (ack) begin
                        state_d   = IDLE;
                        restart_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and result registers; reset clears everything without a restart pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            round_q    <= '0;
            scores_q   <= '0;
            champion_q <= '0;
            illegal_q  <= 1'b0;
            restart_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            scores_q   <= scores_d;
            champion_q <= champion_d;
            illegal_q  <= illegal_d;
            restart_q  <= restart_d;
        end
    end

    assign round          = round_q;
    assign scores         = scores_q;
    assign playing        = (state_q == PLAY);
    assign match_over     = (state_q == OVER);
    assign champion       = champion_q;
    assign illegal_winner = illegal_q;
    assign restartgame    = restart_q;

endmodule

// File: tb/tb_match_scoreboard.sv
// tb/tb_match_scoreboard.sv - directed scoreboard bench for match_scoreboard (default and 4-player builds)
module tb_match_scoreboard;

    typedef struct packed {
        logic [2:0] rnd;
        logic [7:0] sc;
        logic       pl;
        logic       ov;
        logic [3:0] ch;
        logic       il;
        logic       rs;
    } exp_t;

    exp_t sb_q[$];
    int   passed = 0;
    int   total  = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       a_start = 1'b0, a_ack = 1'b0, a_done = 1'b0;
    logic [1:0] a_win = '0;
    logic [1:0] a_round;
    logic [3:0] a_scores;
    logic       a_playing, a_over, a_ill, a_rs;
    logic [1:0] a_champ;

    logic       b_start = 1'b0, b_ack = 1'b0, b_done = 1'b0;
    logic [3:0] b_win = '0;
    logic [2:0] b_round;
    logic [7:0] b_scores;
    logic       b_playing, b_over, b_ill, b_rs;
    logic [3:0] b_champ;

    always #5 clk = ~clk;

    match_scoreboard u_a (
        .clk(clk), .reset(reset), .start(a_start), .ack(a_ack), .round_done(a_done),
        .round_winner(a_win), .round(a_round), .scores(a_scores), .playing(a_playing),
        .match_over(a_over), .champion(a_champ), .illegal_winner(a_ill), .restartgame(a_rs)
    );

    match_scoreboard #(.NUM_PLAYERS(4), .MAX_ROUNDS(5), .WIN_SCORE(3), .SCORE_W(2)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .ack(b_ack), .round_done(b_done),
        .round_winner(b_win), .round(b_round), .scores(b_scores), .playing(b_playing),
        .match_over(b_over), .champion(b_champ), .illegal_winner(b_ill), .restartgame(b_rs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] r, input logic [7:0] sc,
                             input logic pl, input logic ov, input logic [3:0] ch,
                             input logic il, input logic rs);
        exp_t e;
        e = sb_q.pop_front();
        chk({tag, ".round"},       32'(r),  32'(e.rnd));
        chk({tag, ".scores"},      32'(sc), 32'(e.sc));
        chk({tag, ".playing"},     32'(pl), 32'(e.pl));
        chk({tag, ".match_over"},  32'(ov), 32'(e.ov));
        chk({tag, ".champion"},    32'(ch), 32'(e.ch));
        chk({tag, ".illegal"},     32'(il), 32'(e.il));
        chk({tag, ".restartgame"}, 32'(rs), 32'(e.rs));
    endtask

    task automatic sample_a(input string tag);
        check_out(tag, 3'(a_round), 8'(a_scores), a_playing, a_over, 4'(a_champ), a_ill, a_rs);
    endtask

    task automatic step_a(input string tag, input logic s, input logic k, input logic d,
                          input logic [1:0] w, input exp_t e);
        sb_q.push_back(e);
        a_start = s; a_ack = k; a_done = d; a_win = w;
        @(posedge clk);
        @(negedge clk);
        sample_a(tag);
        a_start = 1'b0; a_ack = 1'b0; a_done = 1'b0; a_win = '0;
    endtask

    task automatic step_b(input string tag, input logic s, input logic k, input logic d,
                          input logic [3:0] w, input exp_t e);
        sb_q.push_back(e);
        b_start = s; b_ack = k; b_done = d; b_win = w;
        @(posedge clk);
        @(negedge clk);
        check_out(tag, b_round, b_scores, b_playing, b_over, b_champ, b_ill, b_rs);
        b_start = 1'b0; b_ack = 1'b0; b_done = 1'b0; b_win = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        //                                        rnd    sc     pl    ov    ch       il    rs
        repeat (2) @(negedge clk);
        sb_q.push_back(exp_t'{3'd0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0});
        sample_a("in_reset");
        reset = 1'b1;
        step_a("idle",       0, 0, 0, 2'b00, exp_t'{3'd0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0});

        // win threshold reached on second round
        step_a("start",      1, 0, 0, 2'b00, exp_t'{3'd0, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1});
        step_a("w01_a",      0, 0, 1, 2'b01, exp_t'{3'd1, 8'h01, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0});
        step_a("w01_b",      0, 0, 1, 2'b01, exp_t'{3'd2, 8'h02, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0});
        step_a("over_done",  0, 0, 1, 2'b10, exp_t'{3'd2, 8'h02, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0});
        step_a("ack",        0, 1, 0, 2'b00, exp_t'{3'd2, 8'h02, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1});
        step_a("idle_done",  0, 1, 1, 2'b01, exp_t'{3'd2, 8'h02, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0});

        // round limit with tied leaders
        step_a("start2",     1, 0, 0, 2'b00, exp_t'{3'd0, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1});
        step_a("t_w01",      0, 0, 1, 2'b01, exp_t'{3'd1, 8'h01, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0});
        step_a("t_w10",      0, 0, 1, 2'b10, exp_t'{3'd2, 8'h05, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0});
        step_a("t_w00",      0, 0, 1, 2'b00, exp_t'{3'd3, 8'h05, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0});

        // start beats ack in OVER; multi-hot winner is a flagged draw
        step_a("start_ack",  1, 1, 0, 2'b00, exp_t'{3'd0, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1});
        step_a("w11",        0, 0, 1, 2'b11, exp_t'{3'd1, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0});
        step_a("ill_sticky", 0, 0, 1, 2'b01, exp_t'{3'd2, 8'h01, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0});

        // start drops a simultaneous round_done; restart pulse lasts one cycle
        step_a("start_done", 1, 0, 1, 2'b01, exp_t'{3'd0, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1});
        step_a("pulse_end",  0, 0, 0, 2'b00, exp_t'{3'd0, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 0});
        step_a("w10_c",      0, 0, 1, 2'b10, exp_t'{3'd1, 8'h04, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0});

        // asynchronous reset mid-match, then no pulse on release
        #2 reset = 1'b0;
        #1;
        sb_q.push_back(exp_t'{3'd0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0});
        sample_a("async_rst");
        @(negedge clk);
        reset = 1'b1;
        step_a("post_rst",   0, 0, 0, 2'b00, exp_t'{3'd0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0});
        step_a("start3",     1, 0, 0, 2'b00, exp_t'{3'd0, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1});

        // four players, five rounds, win at three
        step_b("b_start",    1, 0, 0, 4'b0000, exp_t'{3'd0, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1});
        step_b("b_r1",       0, 0, 1, 4'b0100, exp_t'{3'd1, 8'h10, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0});
        step_b("b_r2",       0, 0, 1, 4'b0010, exp_t'{3'd2, 8'h14, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0});
        step_b("b_r3",       0, 0, 1, 4'b0100, exp_t'{3'd3, 8'h24, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0});
        step_b("b_r4",       0, 0, 1, 4'b1000, exp_t'{3'd4, 8'h64, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0});
        step_b("b_r5",       0, 0, 1, 4'b0100, exp_t'{3'd5, 8'h74, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0});
        step_b("b_r6",       0, 0, 1, 4'b0001, exp_t'{3'd5, 8'h74, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0});
        step_b("b_ack",      0, 1, 0, 4'b0000, exp_t'{3'd5, 8'h74, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1});
        step_b("b_idle",     0, 0, 0, 4'b0000, exp_t'{3'd5, 8'h74, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
